// File: rtl/d_edge_interval_mon.sv
// Transition monitor for a single data line: queues {level, interval, saturated} records per edge.
// Optional macro EDGE_MON_SYNC_EN adds a synchronizer stage for an asynchronous d_in.
module d_edge_interval_mon #(
  parameter int CNT_W   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_in,
  input  logic               cap_ready,
  input  logic               ovf_clr,
  output logic               cap_valid,
  output logic               cap_level,
  output logic [CNT_W-1:0]   cap_interval,
  output logic               cap_sat,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               d_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int REC_W = CNT_W + 2;
  localparam logic [CNT_W-1:0]   MAX_CNT  = '1;
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic w_src;
  logic w_src_vld;

`ifdef EDGE_MON_SYNC_EN
  logic r_meta;
  logic r_meta_vld;

  // r_meta plus r_d_s form the two synchronizer flops; arming waits until r_meta holds a real sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta     <= 1'b0;
      r_meta_vld <= 1'b0;
    end else begin
      r_meta     <= d_in;
      r_meta_vld <= 1'b1;
    end
  end

  assign w_src     = r_meta;
  assign w_src_vld = r_meta_vld;
`else
  assign w_src     = d_in;
  assign w_src_vld = 1'b1;
`endif

  logic r_d_s;
  logic r_d_prev;
  logic r_armed;
  logic [CNT_W-1:0] r_cnt;

  logic             w_edge;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_sat;
  logic [CNT_W-1:0] w_interval;

  assign w_edge     = r_armed & (r_d_s ^ r_d_prev);
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_sat      = (w_cnt_inc >= {1'b0, MAX_CNT});
  assign w_interval = w_sat ? MAX_CNT : w_cnt_inc[CNT_W-1:0];

  // On the arm edge d_prev takes the value d_s is loading, so a static level never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_s    <= 1'b0;
      r_d_prev <= 1'b0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_d_s    <= w_src;
      r_d_prev <= r_armed ? r_d_s : w_src;
      if (!r_armed && w_src_vld)
        r_armed <= 1'b1;
      if (!r_armed || w_edge)
        r_cnt <= '0;
      else
        r_cnt <= w_interval;
    end
  end

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic             r_ovf;

  logic [FIFO_AW:0] w_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == FULL_CNT);
  assign w_pop   = cap_valid & cap_ready;
  assign w_push  = w_edge & (~w_full | w_pop);
  assign w_drop  = w_edge & w_full & ~w_pop;
  assign w_rec   = {r_d_s, w_sat, w_interval};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_rec;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  // Show-ahead head read; fields read as zero while the queue is empty
  assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign cap_valid  = (w_count != '0);
  assign {cap_level, cap_sat, cap_interval} = cap_valid ? w_head : '0;
  assign fifo_count = w_count;
  assign overflow   = r_ovf;
  assign d_level    = r_d_s;

endmodule
